// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES GF(2^8) helpers, column index type and InvMixColumns FSM states
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef logic [1:0] col_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] a);
    logic [7:0] x8;
    x8 = xtime(xtime(xtime(a)));
    return x8 ^ a;
  endfunction

  function automatic logic [7:0] gf_mulb(input logic [7:0] a);
    logic [7:0] x2, x8;
    x2 = xtime(a);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ a;
  endfunction

  function automatic logic [7:0] gf_muld(input logic [7:0] a);
    logic [7:0] x4, x8;
    x4 = xtime(xtime(a));
    x8 = xtime(x4);
    return x8 ^ x4 ^ a;
  endfunction

  function automatic logic [7:0] gf_mule(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/inv_mix_columns_iter_if.sv
// rtl/inv_mix_columns_iter_if.sv - valid/ready channel carrying one 128-bit AES state
interface inv_mix_columns_iter_if;
  logic         valid;
  logic         ready;
  logic [127:0] state;

  modport master (output valid, output state, input ready);
  modport slave  (input valid, input state, output ready);
endinterface

// File: rtl/inv_mix_columns_iter_column32.sv
// rtl/inv_mix_columns_iter_column32.sv - combinational InvMixColumns of one 32-bit column
module inv_mix_column32
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  assign col_o[31:24] = gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3);
  assign col_o[23:16] = gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3) ^ gf_mul9(a0);
  assign col_o[15:8]  = gf_mule(a2) ^ gf_mulb(a3) ^ gf_muld(a0) ^ gf_mul9(a1);
  assign col_o[7:0]   = gf_mule(a3) ^ gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2);

endmodule

// File: rtl/inv_mix_columns_iter.sv
// rtl/inv_mix_columns_iter.sv - iterative AES InvMixColumns, COLS_PER_CYCLE columns per clock
module inv_mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  inv_mix_columns_iter_if.slave         in_if,
  inv_mix_columns_iter_if.master        out_if,
  output logic                          busy_o
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $fatal(1, "inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam col_t STEP     = col_t'(COLS_PER_CYCLE % 4);
  localparam col_t LAST_COL = col_t'(4 - COLS_PER_CYCLE);

  state_t           state_q, state_d;
  col_t             col_q, col_d;
  // Packed element 3-c holds column c, so ~col selects column col.
  logic [3:0][31:0] src_q, src_d;
  logic [3:0][31:0] res_q, res_d;
  logic [31:0]      xf  [COLS_PER_CYCLE];
  col_t             idx [COLS_PER_CYCLE];
  logic             in_ready;
  logic             accept;

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    assign idx[k] = col_q + col_t'(k);
    inv_mix_column32 u_col (
      .col_i (src_q[~idx[k]]),
      .col_o (xf[k])
    );
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    src_d    = src_q;
    res_d    = res_q;
    in_ready = (state_q == IDLE) || (state_q == DONE && out_if.ready);
    accept   = in_if.valid && in_ready;

    case (state_q)
      IDLE: begin
        if (accept) begin
          src_d   = in_if.state;
          col_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          res_d[~idx[k]] = xf[k];
        end
        col_d = col_q + STEP;
        if (col_q == LAST_COL) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (accept) begin
          src_d   = in_if.state;
          col_d   = '0;
          state_d = BUSY;
        end else if (out_if.ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      col_q   <= '0;
      src_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      src_q   <= src_d;
      res_q   <= res_d;
    end
  end

  assign in_if.ready  = in_ready;
  assign out_if.valid = (state_q == DONE);
  assign out_if.state = res_q;
  assign busy_o       = (state_q == BUSY);

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// tb/tb_inv_mix_columns_iter.sv - directed and round-trip checks of inv_mix_columns_iter
module tb_inv_mix_columns_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic busy1, busy2, busy4;
  int   errors = 0;
  int   checks = 0;

  localparam logic [127:0] V_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] V_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] C6    = {16{8'hc6}};

  inv_mix_columns_iter_if in1 ();
  inv_mix_columns_iter_if out1 ();
  inv_mix_columns_iter_if in2 ();
  inv_mix_columns_iter_if out2 ();
  inv_mix_columns_iter_if in4 ();
  inv_mix_columns_iter_if out4 ();

  inv_mix_columns_iter #(.COLS_PER_CYCLE(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .in_if(in1), .out_if(out1), .busy_o(busy1));
  inv_mix_columns_iter #(.COLS_PER_CYCLE(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .in_if(in2), .out_if(out2), .busy_o(busy2));
  inv_mix_columns_iter #(.COLS_PER_CYCLE(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .in_if(in4), .out_if(out4), .busy_o(busy4));

  // Forward MixColumns reference: feeding mc_state(x) to the DUT must return x.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mc_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] mc_state(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = mc_col(s[127-32*c -: 32]);
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one state on dut1 and wait (bounded) for out_valid; leaves the DUT in DONE.
  task automatic run_one(input logic [127:0] st, output logic [127:0] res, output int lat);
    in1.valid = 1'b1;
    in1.state = st;
    tick();
    in1.valid = 1'b0;
    in1.state = ~st;
    lat = 0;
    while (!out1.valid && lat < 20) begin
      tick();
      lat++;
    end
    res = out1.state;
  endtask

  task automatic drain1();
    out1.ready = 1'b1;
    tick();
    out1.ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++;
    if (in1.ready !== 1'b1 || out1.valid !== 1'b0 || busy1 !== 1'b0 || out1.state !== 128'h0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b out_state=%h, required 1 0 0 0",
               in1.ready, out1.valid, busy1, out1.state);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_vector();
    logic [127:0] res;
    int lat;
    run_one(V_IN, res, lat);
    checks++;
    if (res !== V_OUT) begin
      errors++;
      $display("FAIL single_vector: got %h, required %h", res, V_OUT);
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL single_latency: got %0d, required 4", lat);
    end
    drain1();
  endtask

  task automatic test_backpressure();
    int n;
    in1.valid = 1'b1;
    in1.state = C6;
    tick();
    in1.valid = 1'b0;
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL bp_busy_after_accept: got %b, required 1", busy1);
    end
    n = 0;
    while (!out1.valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (out1.state !== C6) begin
      errors++;
      $display("FAIL same_byte_state: got %h, required %h", out1.state, C6);
    end
    in1.valid = 1'b1;
    in1.state = V_IN;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (out1.state !== C6 || in1.ready !== 1'b0 || out1.valid !== 1'b1 || busy1 !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: out_state=%h in_ready=%b out_valid=%b busy=%b, required %h 0 1 0",
                 c, out1.state, in1.ready, out1.valid, busy1, C6);
      end
    end
    out1.ready = 1'b1;
    #1;
    checks++;
    if (in1.ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_in_ready_on_out_ready: got %b, required 1", in1.ready);
    end
    tick();
    in1.valid = 1'b0;
    out1.ready = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || out1.valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_back_to_back: busy=%b out_valid=%b, required 1 0", busy1, out1.valid);
    end
    n = 0;
    while (!out1.valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (out1.state !== V_OUT) begin
      errors++;
      $display("FAIL bp_second_result: got %h, required %h", out1.state, V_OUT);
    end
    drain1();
  endtask

  task automatic test_zero();
    logic [127:0] res;
    int lat;
    run_one(128'h0, res, lat);
    checks++;
    if (res !== 128'h0 || lat !== 4) begin
      errors++;
      $display("FAIL zero_state: got %h lat %0d, required 0 lat 4", res, lat);
    end
    drain1();
  endtask

  task automatic test_back_to_back();
    logic [127:0] xs [8];
    int i, j, cyc, last;
    bit acc;
    for (int k = 0; k < 8; k++) xs[k] = rand128();
    i = 0; j = 0; cyc = 0; last = 0;
    out1.ready = 1'b1;
    in1.valid = 1'b1;
    in1.state = mc_state(xs[0]);
    while (j < 8 && cyc < 200) begin
      @(negedge clk);
      acc = in1.valid && in1.ready;
      if (out1.valid && out1.ready) begin
        checks++;
        if (out1.state !== xs[j]) begin
          errors++;
          $display("FAIL stream_result %0d: got %h, required %h", j, out1.state, xs[j]);
        end
        if (j > 0) begin
          checks++;
          if (cyc - last !== 5) begin
            errors++;
            $display("FAIL stream_spacing %0d: got %0d cycles, required 5", j, cyc - last);
          end
        end
        last = cyc;
        j++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        i++;
        if (i < 8) in1.state = mc_state(xs[i]);
        else in1.valid = 1'b0;
      end
    end
    checks++;
    if (j !== 8) begin
      errors++;
      $display("FAIL stream_count: got %0d results, required 8", j);
    end
    in1.valid = 1'b0;
    out1.ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_busy();
    logic [127:0] res;
    int lat;
    in1.valid = 1'b1;
    in1.state = V_IN;
    tick();
    in1.valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out1.valid !== 1'b0 || in1.ready !== 1'b1 || out1.state !== 128'h0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_busy: out_valid=%b in_ready=%b out_state=%h busy=%b, required 0 1 0 0",
               out1.valid, in1.ready, out1.state, busy1);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (out1.valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_stale_valid cycle %0d: got %b, required 0", c, out1.valid);
      end
    end
    run_one(V_IN, res, lat);
    checks++;
    if (res !== V_OUT || lat !== 4) begin
      errors++;
      $display("FAIL reset_fresh_state: got %h lat %0d, required %h lat 4", res, lat, V_OUT);
    end
    drain1();
  endtask

  task automatic test_wide_round_trip();
    logic [127:0] x, r2, r4;
    int lat2, lat4;
    out2.ready = 1'b1;
    out4.ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      x = (n == 0) ? V_OUT : rand128();
      in2.valid = 1'b1; in2.state = mc_state(x);
      in4.valid = 1'b1; in4.state = mc_state(x);
      tick();
      in2.valid = 1'b0; in2.state = ~x;
      in4.valid = 1'b0; in4.state = ~x;
      lat2 = -1; lat4 = -1; r2 = '0; r4 = '0;
      for (int c = 1; c <= 4; c++) begin
        if (out2.valid && lat2 < 0) begin lat2 = c - 1; r2 = out2.state; end
        if (out4.valid && lat4 < 0) begin lat4 = c - 1; r4 = out4.state; end
        tick();
      end
      checks++;
      if (r2 !== x || lat2 !== 2) begin
        errors++;
        $display("FAIL wide2_round_trip %0d: got %h lat %0d, required %h lat 2", n, r2, lat2, x);
      end
      checks++;
      if (r4 !== x || lat4 !== 1) begin
        errors++;
        $display("FAIL wide4_round_trip %0d: got %h lat %0d, required %h lat 1", n, r4, lat4, x);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in1.valid = 1'b0; in1.state = '0; out1.ready = 1'b0;
    in2.valid = 1'b0; in2.state = '0; out2.ready = 1'b0;
    in4.valid = 1'b0; in4.state = '0; out4.ready = 1'b0;
    test_reset();
    test_single_vector();
    test_backpressure();
    test_zero();
    test_back_to_back();
    test_reset_mid_busy();
    test_wide_round_trip();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
